// File: rtl/projectile_scheduler_if.sv
// Fire request/acknowledge handshake between the game logic and the projectile scheduler.
interface projectile_scheduler_if;
    logic        playerFireReq;
    logic [10:0] playerX;
    logic [10:0] playerY;
    logic        alienFireReq;
    logic [10:0] alienX;
    logic [10:0] alienY;
    logic        playerFireAck;
    logic        alienFireAck;

    modport master (
        output playerFireReq, playerX, playerY, alienFireReq, alienX, alienY,
        input  playerFireAck, alienFireAck
    );

    modport slave (
        input  playerFireReq, playerX, playerY, alienFireReq, alienX, alienY,
        output playerFireAck, alienFireAck
    );
endinterface

// File: rtl/projectile_scheduler.sv
// Projectile slot allocator, per-frame mover and pixel hit-tester for a shared 32x32 bitmap.
// Optional hit counter enabled by defining PROJ_HIT_COUNTER_EN.
module projectile_scheduler #(
    parameter int unsigned NUM_SLOTS     = 4,
    parameter int unsigned SPEED         = 4,
    parameter int unsigned SCREEN_BOTTOM = 479
) (
    input  logic                 clk,
    input  logic                 resetN,
    projectile_scheduler_if.slave fire,
    input  logic                 startOfFrame,
    input  logic [10:0]          pixelX,
    input  logic [10:0]          pixelY,
    input  logic                 collision,
    output logic [10:0]          offsetX,
    output logic [10:0]          offsetY,
    output logic                 InsideRectangle,
    output logic [NUM_SLOTS-1:0] slotActive,
    output logic [NUM_SLOTS-1:0] slotIsAlien,
    output logic [7:0]           hitCount
);
    localparam int unsigned CW    = 11;
    localparam int unsigned XW    = 12;
    localparam int unsigned OBJ   = 32;
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);

    logic [NUM_SLOTS-1:0] r_active;
    logic [NUM_SLOTS-1:0] r_alien;
    logic [CW-1:0]        r_x [NUM_SLOTS];
    logic [CW-1:0]        r_y [NUM_SLOTS];
    logic                 r_last_alien;
    logic                 r_player_ack;
    logic                 r_alien_ack;
    logic                 r_inside;
    logic [CW-1:0]        r_off_x;
    logic [CW-1:0]        r_off_y;
    logic                 r_vld_d1;
    logic                 r_vld_d2;
    logic [IDX_W-1:0]     r_win_d1;
    logic [IDX_W-1:0]     r_win_d2;

    logic [NUM_SLOTS-1:0] w_kill;
    logic [NUM_SLOTS-1:0] w_free;
    logic                 w_any_free;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_player_live;
    logic                 w_player_elig;
    logic                 w_alien_elig;
    logic                 w_grant_player;
    logic                 w_grant_alien;
    logic [CW-1:0]        w_player_spawn_y;
    logic [XW-1:0]        w_alien_sum;
    logic [CW-1:0]        w_alien_spawn_y;
    logic                 w_cover_any;
    logic [IDX_W-1:0]     w_cover_idx;
    logic [CW-1:0]        w_cover_dx;
    logic [CW-1:0]        w_cover_dy;

    // Collision reported against the pixel two cycles old kills that pixel's winning slot.
    always_comb begin
        w_kill = '0;
        if (collision && r_vld_d2 && r_active[r_win_d2]) begin
            w_kill[r_win_d2] = 1'b1;
        end
    end

    // Allocation: lowest free slot; ties between requesters alternate on r_last_alien.
    always_comb begin
        w_free     = ~r_active & ~w_kill;
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_any_free = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
        w_player_live  = |(r_active & ~r_alien);
        w_player_elig  = fire.playerFireReq && !w_player_live && w_any_free;
        w_alien_elig   = fire.alienFireReq && w_any_free;
        w_grant_player = w_player_elig && (!w_alien_elig || r_last_alien);
        w_grant_alien  = w_alien_elig && !w_grant_player;
    end

    // Spawn positions, clamped at both ends of the 11-bit range.
    always_comb begin
        w_player_spawn_y = (fire.playerY < CW'(OBJ)) ? '0 : (fire.playerY - CW'(OBJ));
        w_alien_sum      = {1'b0, fire.alienY} + XW'(OBJ);
        w_alien_spawn_y  = w_alien_sum[XW-1] ? '1 : w_alien_sum[CW-1:0];
    end

    // Pixel cover test; lowest-index covering slot wins.
    always_comb begin
        w_cover_any = 1'b0;
        w_cover_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_active[i]
                && ({1'b0, pixelX} >= {1'b0, r_x[i]})
                && ({1'b0, pixelX} <  ({1'b0, r_x[i]} + XW'(OBJ)))
                && ({1'b0, pixelY} >= {1'b0, r_y[i]})
                && ({1'b0, pixelY} <  ({1'b0, r_y[i]} + XW'(OBJ)))) begin
                w_cover_any = 1'b1;
                w_cover_idx = IDX_W'(i);
            end
        end
        w_cover_dx = pixelX - r_x[w_cover_idx];
        w_cover_dy = pixelY - r_y[w_cover_idx];
    end

    always_ff @(posedge clk) begin
        if (resetN) begin
            r_active     <= '0;
            r_alien      <= '0;
            r_last_alien <= 1'b1;
            r_player_ack <= 1'b0;
            r_alien_ack  <= 1'b0;
            r_inside     <= 1'b0;
            r_off_x      <= '0;
            r_off_y      <= '0;
            r_vld_d1     <= 1'b0;
            r_vld_d2     <= 1'b0;
            r_win_d1     <= '0;
            r_win_d2     <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_player_ack <= w_grant_player;
            r_alien_ack  <= w_grant_alien;
            if (w_grant_player || w_grant_alien) begin
                r_last_alien <= w_grant_alien;
            end

            r_inside <= w_cover_any;
            r_off_x  <= w_cover_any ? w_cover_dx : '0;
            r_off_y  <= w_cover_any ? w_cover_dy : '0;
            r_vld_d1 <= w_cover_any;
            r_win_d1 <= w_cover_idx;
            r_vld_d2 <= r_vld_d1;
            r_win_d2 <= r_win_d1;

            // Kill takes priority over frame movement; off-screen slots retire.
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_kill[i]) begin
                    r_active[i] <= 1'b0;
                end else if (r_active[i] && startOfFrame) begin
                    if (!r_alien[i]) begin
                        if ({1'b0, r_y[i]} < XW'(SPEED)) r_active[i] <= 1'b0;
                        else                             r_y[i] <= r_y[i] - CW'(SPEED);
                    end else begin
                        if (({1'b0, r_y[i]} + XW'(SPEED) + XW'(OBJ)) > XW'(SCREEN_BOTTOM))
                            r_active[i] <= 1'b0;
                        else
                            r_y[i] <= r_y[i] + CW'(SPEED);
                    end
                end
            end

            if (w_grant_player || w_grant_alien) begin
                r_active[w_free_idx] <= 1'b1;
                r_alien[w_free_idx]  <= w_grant_alien;
                r_x[w_free_idx]      <= w_grant_alien ? fire.alienX : fire.playerX;
                r_y[w_free_idx]      <= w_grant_alien ? w_alien_spawn_y : w_player_spawn_y;
            end
        end
    end

`ifdef PROJ_HIT_COUNTER_EN
    logic [7:0] r_hit_count;

    // Saturating count of player projectiles destroyed by collision.
    always_ff @(posedge clk) begin
        if (resetN) begin
            r_hit_count <= '0;
        end else if ((|w_kill) && !r_alien[r_win_d2] && (r_hit_count != 8'hFF)) begin
            r_hit_count <= r_hit_count + 8'd1;
        end
    end

    assign hitCount = r_hit_count;
`else
    assign hitCount = 8'd0;
`endif

    assign fire.playerFireAck = r_player_ack;
    assign fire.alienFireAck  = r_alien_ack;
    assign offsetX            = r_off_x;
    assign offsetY            = r_off_y;
    assign InsideRectangle    = r_inside;
    assign slotActive         = r_active;
    assign slotIsAlien        = r_alien;
endmodule

// File: doc/projectile_scheduler.md
PROJECTILE_SCHEDULER -- requirements
Module: projectile_scheduler

Interface
REQ-001 Parameters: NUM_SLOTS, 4, number of projectile slots (2..8).
REQ-002 Parameters: SPEED, 4, pixels moved per frame.
REQ-003 Parameters: SCREEN_BOTTOM, 479, last visible Y row.
REQ-004 Ports: clk in 1, system clock; resetN in 1, synchronous active-high reset (asserted = 1).
REQ-005 Ports: startOfFrame in 1, one-cycle pulse per frame; pixelX, pixelY in 11 each, current scan pixel.
REQ-006 Ports: playerFireReq in 1, level request held until ack; playerX, playerY in 11 each, player top-left.
REQ-007 Ports: alienFireReq in 1, level request held until ack; alienX, alienY in 11 each, shooting alien's top-left.
REQ-008 Ports: collision in 1, bitmap drawingRequest overlapped another object on the pixel two cycles after pixelX/Y.
REQ-009 Ports: playerFireAck, alienFireAck out 1 each, one-cycle grant pulses.
REQ-010 Ports: offsetX, offsetY out 11 each; InsideRectangle out 1; drive the shared 32x32 projectile bitmap.
REQ-011 Ports: slotActive out NUM_SLOTS; slotIsAlien out NUM_SLOTS; hitCount out 8.

Function
REQ-012 Each slot SHALL hold active, owner (player/alien), topLeftX, topLeftY (11 bits each).
REQ-013 Allocation SHALL pick the lowest-index inactive slot; with no free slot, requests stay pending and no ack is issued.
REQ-014 At most one active player-owned slot; playerFireReq SHALL be ignored (no ack) while one exists.
REQ-015 Both requests eligible in one cycle: grant SHALL alternate via a lastGrant register (reset value: alien, so player wins first tie); only one allocation per cycle.
REQ-016 Ack SHALL be registered: asserted for exactly one cycle, in the cycle after the granting request was sampled; the slot is active in that same cycle.
REQ-017 Player spawn: topLeftX = playerX, topLeftY = playerY-32, saturated to 0 if playerY < 32; alien spawn: topLeftX = alienX, topLeftY = alienY+32.
REQ-018 On startOfFrame, each active player slot SHALL do Y -= SPEED and each active alien slot Y += SPEED; a slot allocated in that cycle is not moved.
REQ-019 Player slot with Y < SPEED at startOfFrame SHALL deactivate instead of moving; alien slot with Y+SPEED+32 > SCREEN_BOTTOM SHALL deactivate.
REQ-020 Per pixel, slot i covers pixelX in [X, X+32) and pixelY in [Y, Y+32); lowest active covering index wins.
REQ-021 Registered outputs (latency 1): InsideRectangle = any cover; offsetX/Y = pixel minus winner's top-left; offsets = 0 when no cover.
REQ-022 Winner index and valid SHALL be delayed two cycles total to align with collision; collision with delayed valid deactivates that slot.
REQ-023 Kill and startOfFrame movement on the same slot in one cycle: kill wins. A slot being killed is not free for allocation that cycle.
REQ-024 Addition/comparison SHALL use 12-bit intermediates; no 11-bit wrap-around allowed.
REQ-025 slotActive/slotIsAlien SHALL reflect registered slot state.

Reset
REQ-026 resetN = 1 at clk edge: all slots inactive, coordinates 0, acks 0, InsideRectangle 0, offsets 0, pipeline valids 0, hitCount 0, lastGrant = alien.
REQ-027 Reset mid-operation SHALL discard pending requests and in-flight pipeline kills; no ack in the cycle after reset deasserts unless a request is sampled in that cycle.

Configuration
REQ-028 Macro PROJ_HIT_COUNTER_EN defined: hitCount increments on each collision kill of a player-owned slot, saturates at 255.
REQ-029 Macro PROJ_HIT_COUNTER_EN undefined: hitCount port present, constant 0, no counter logic.

Verification
REQ-030 Reset, then playerFireReq = 1 with playerX = 100, playerY = 400 -> playerFireAck pulse next cycle, slot0 active, Y = 368; request held -> no second ack.
REQ-031 Both requests in the same cycle, twice (player re-armed after a kill) -> first grant player, second grant alien.
REQ-032 Fill all 4 slots, then alienFireReq -> no ack until a slot frees, then ack the cycle after the free.
REQ-033 Player slot at Y = 3, startOfFrame -> slot deactivates; alien slot at Y = 444, startOfFrame -> deactivates (444+4+32 > 479).
REQ-034 Pixel (105, 370) with slot0 at (100, 368) -> next cycle InsideRectangle = 1, offsetX = 5, offsetY = 2; collision two cycles after the pixel -> slot0 inactive, hitCount = 1 with macro, 0 without.
REQ-035 collision and startOfFrame in the same cycle on a moving slot -> slot inactive, no movement applied.
